// File: rtl/event_emitter_pkg.sv
// Shared types and the event-word packing helper for the spike-event FIFO protocol.
// The capture stage unpacks with the same layout: {ts, x, y, spikes}, spikes in the LSBs.
package event_emitter_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      MARK  = 2'd2
   } emit_state_t;

   // Widest word the helper can build; callers truncate to their own DATA_W.
   localparam int PACK_W = 64;

   function automatic logic [PACK_W-1:0] pack_event(
      input logic              ts,
      input logic [PACK_W-1:0] x,
      input logic [PACK_W-1:0] y,
      input logic [PACK_W-1:0] spikes,
      input int                coord_bits,
      input int                channels
   );
      return (PACK_W'(ts) << (2*coord_bits + channels))
           | (x << (coord_bits + channels))
           | (y << channels)
           | spikes;
   endfunction

endpackage

// File: rtl/event_emitter_if.sv
// Handshake bundle of the event emitter: upstream event channel, marker request
// channel and the downstream layer-FIFO write port.
interface event_emitter_if #(
   parameter int COORD_BITS = 7,
   parameter int CHANNELS   = 8
);
   localparam int DATA_W = 2*COORD_BITS + CHANNELS + 1;

   logic                  ev_valid;
   logic                  ev_ready;
   logic [COORD_BITS-1:0] ev_x;
   logic [COORD_BITS-1:0] ev_y;
   logic [CHANNELS-1:0]   ev_spikes;
   logic                  ts_valid;
   logic                  ts_ready;
   logic [DATA_W-1:0]     fifo_write_data;
   logic                  fifo_write_en;
   logic                  fifo_full_next;

   // Master: the producer datapath together with the downstream FIFO.
   modport master (
      output ev_valid, ev_x, ev_y, ev_spikes, ts_valid, fifo_full_next,
      input  ev_ready, ts_ready, fifo_write_data, fifo_write_en
   );

   modport slave (
      input  ev_valid, ev_x, ev_y, ev_spikes, ts_valid, fifo_full_next,
      output ev_ready, ts_ready, fifo_write_data, fifo_write_en
   );
endinterface

// File: rtl/event_emit_buf.sv
// Two-entry FIFO of packed event words; push and pop may happen on the same edge.
module event_emit_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem_q [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: storage is deliberately left out of reset; cnt_q alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/event_emitter.sv
// Transmit side of the spike-event FIFO protocol: packs spike vectors into event
// words, writes them downstream and inserts timestep markers after earlier events.
module event_emitter
   import event_emitter_pkg::*;
#(
   parameter int COORD_BITS = 7,
   parameter int CHANNELS   = 8,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   event_emitter_if.slave     bus,
   output logic               busy,
   output logic [COUNT_W-1:0] event_count
);
   localparam int DATA_W = 2*COORD_BITS + CHANNELS + 1;

   emit_state_t        state_q, state_d;
   logic               wr_en_q, wr_en_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               ts_ready_q, ts_ready_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic               buf_push, buf_pop, buf_full, buf_empty;
   logic [DATA_W-1:0]  buf_rdata, event_word, marker_word;
   logic               ev_ready;

   assign event_word  = DATA_W'(pack_event(1'b0, PACK_W'(bus.ev_x), PACK_W'(bus.ev_y),
                                           PACK_W'(bus.ev_spikes), COORD_BITS, CHANNELS));
   assign marker_word = DATA_W'(pack_event(1'b1, '0, '0, '0, COORD_BITS, CHANNELS));

   // Held low while reset is asserted so nothing is accepted into a buffer being cleared.
   assign ev_ready = rst_n & enable & (state_q == RUN) & ~buf_full;
   // Zero spike vectors complete the handshake but are dropped here.
   assign buf_push = bus.ev_valid & ev_ready & (|bus.ev_spikes);

   event_emit_buf #(.W(DATA_W)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (buf_push),
      .pop   (buf_pop),
      .wdata (event_word),
      .rdata (buf_rdata),
      .full  (buf_full),
      .empty (buf_empty)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      wr_en_d    = 1'b0;
      data_d     = data_q;
      ts_ready_d = 1'b0;
      count_d    = count_q;
      buf_pop    = 1'b0;

      if (enable) begin
         if (!buf_empty && !bus.fifo_full_next) begin
            buf_pop = 1'b1;
            wr_en_d = 1'b1;
            data_d  = buf_rdata;
            if (count_q != '1) count_d = count_q + 1'b1;
         end

         unique case (state_q)
            // ts_ready_q masks the request still high in the cycle its marker goes out.
            RUN:     if (bus.ts_valid && !ts_ready_q) state_d = DRAIN;
            DRAIN:   if (buf_empty) state_d = MARK;
            MARK: begin
               if (!bus.fifo_full_next) begin
                  wr_en_d    = 1'b1;
                  data_d     = marker_word;
                  ts_ready_d = 1'b1;
                  state_d    = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wr_en_q    <= 1'b0;
         data_q     <= '0;
         ts_ready_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_en_q    <= wr_en_d;
         data_q     <= data_d;
         ts_ready_q <= ts_ready_d;
         count_q    <= count_d;
      end
   end

   assign bus.ev_ready        = ev_ready;
   assign bus.ts_ready        = ts_ready_q;
   assign bus.fifo_write_en   = wr_en_q;
   assign bus.fifo_write_data = data_q;
   assign busy                = ~buf_empty | (state_q != RUN);
   assign event_count         = count_q;

endmodule

// File: tb/tb_event_emitter.sv
// Directed bench for event_emitter at COORD_BITS=4, CHANNELS=4 (13-bit words).
module tb_event_emitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        busy;
   logic [15:0] event_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [12:0] wq [$];
   int          wc [$];

   event_emitter_if #(.COORD_BITS(4), .CHANNELS(4)) bus ();

   event_emitter #(.COORD_BITS(4), .CHANNELS(4), .COUNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .bus         (bus),
      .busy        (busy),
      .event_count (event_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.fifo_write_en === 1'b1) begin
         wq.push_back(bus.fifo_write_data);
         wc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] ew(input logic [3:0] x, input logic [3:0] y, input logic [3:0] s);
      return {1'b0, x, y, s};
   endfunction

   // Offers one event, waits (bounded) for ev_ready, completes the handshake.
   task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [3:0] s);
      bit ok = 1'b0;
      bus.ev_valid  = 1'b1;
      bus.ev_x      = x;
      bus.ev_y      = y;
      bus.ev_spikes = s;
      for (int k = 0; k < 20; k++) begin
         if (bus.ev_ready === 1'b1) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      bus.ev_valid = 1'b0;
      check("send_handshake", 32'(ok), 32'd1);
   endtask

   task automatic wait_ts_ready();
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.ts_ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("ts_ready_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      rst_n              = 1'b0;
      enable             = 1'b1;
      bus.ev_valid       = 1'b0;
      bus.ev_x           = '0;
      bus.ev_y           = '0;
      bus.ev_spikes      = '0;
      bus.ts_valid       = 1'b0;
      bus.fifo_full_next = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_ev_ready", 32'(bus.ev_ready), 32'd0);
      check("rst_ts_ready", 32'(bus.ts_ready), 32'd0);
      check("rst_wr_en", 32'(bus.fifo_write_en), 32'd0);
      check("rst_wr_data", 32'(bus.fifo_write_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(event_count), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ev_ready", 32'(bus.ev_ready), 32'd1);

      // Single event: write appears one cycle after accept
      bus.ev_valid = 1'b1; bus.ev_x = 4'd3; bus.ev_y = 4'd5; bus.ev_spikes = 4'b1010;
      tick();
      bus.ev_valid = 1'b0;
      check("single_no_write_yet", 32'(bus.fifo_write_en), 32'd0);
      check("single_busy", 32'(busy), 32'd1);
      tick();
      check("single_wr_en", 32'(bus.fifo_write_en), 32'd1);
      check("single_word", 32'(bus.fifo_write_data), 32'h035A);
      check("single_count", 32'(event_count), 32'd1);
      tick();
      check("single_wr_en_drop", 32'(bus.fifo_write_en), 32'd0);
      check("single_idle", 32'(busy), 32'd0);
      tick();
      wq.delete(); wc.delete();

      // Eight back-to-back events at full rate
      for (int i = 0; i < 8; i++) begin
         bus.ev_valid  = 1'b1;
         bus.ev_x      = 4'(i);
         bus.ev_y      = 4'(i + 1);
         bus.ev_spikes = 4'(i + 1);
         check("burst_ev_ready", 32'(bus.ev_ready), 32'd1);
         tick();
      end
      bus.ev_valid = 1'b0;
      tick(); tick(); tick();
      check("burst_nwords", 32'(wq.size()), 32'd8);
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         check("burst_word", 32'(wq[i]), 32'(ew(4'(i), 4'(i + 1), 4'(i + 1))));
         check("burst_no_bubble", 32'(wc[i] - wc[0]), 32'(i));
      end
      check("burst_count", 32'(event_count), 32'd9);
      wq.delete(); wc.delete();

      // Back-pressure: fifo_full_next high for five edges
      bus.fifo_full_next = 1'b1;
      bus.ev_valid = 1'b1; bus.ev_x = 4'hA; bus.ev_y = 4'h1; bus.ev_spikes = 4'h1;
      tick();
      bus.ev_x = 4'hB; bus.ev_y = 4'h2; bus.ev_spikes = 4'h2;
      tick();
      bus.ev_x = 4'hC; bus.ev_y = 4'h3; bus.ev_spikes = 4'h4;
      check("bp_full_ev_ready", 32'(bus.ev_ready), 32'd0);
      tick(); tick(); tick();
      check("bp_no_writes", 32'(wq.size()), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      bus.fifo_full_next = 1'b0;
      check("bp_still_full", 32'(bus.ev_ready), 32'd0);
      tick();
      check("bp_ready_after_pop", 32'(bus.ev_ready), 32'd1);
      tick();
      bus.ev_valid = 1'b0;
      tick(); tick(); tick();
      check("bp_nwords", 32'(wq.size()), 32'd3);
      if (wq.size() == 3) begin
         check("bp_word0", 32'(wq[0]), 32'h0A11);
         check("bp_word1", 32'(wq[1]), 32'h0B22);
         check("bp_word2", 32'(wq[2]), 32'h0C34);
      end
      check("bp_count", 32'(event_count), 32'd12);
      wq.delete(); wc.delete();

      // Zero spike vector between two events
      send(4'd1, 4'd2, 4'h1);
      send(4'd5, 4'd5, 4'h0);
      send(4'd6, 4'd7, 4'h3);
      tick(); tick(); tick();
      check("zero_nwords", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         check("zero_word0", 32'(wq[0]), 32'h0121);
         check("zero_word1", 32'(wq[1]), 32'h0673);
      end
      check("zero_count", 32'(event_count), 32'd14);
      wq.delete(); wc.delete();

      // Marker with two events buffered
      bus.fifo_full_next = 1'b1;
      send(4'd2, 4'd4, 4'h8);
      send(4'd7, 4'd1, 4'h6);
      bus.ts_valid = 1'b1;
      bus.fifo_full_next = 1'b0;
      tick();
      check("drain_ev_ready", 32'(bus.ev_ready), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
      wait_ts_ready();
      check("mark_wr_en", 32'(bus.fifo_write_en), 32'd1);
      check("mark_word", 32'(bus.fifo_write_data), 32'h1000);
      bus.ts_valid = 1'b0;
      tick();
      check("mark_ts_ready_pulse", 32'(bus.ts_ready), 32'd0);
      check("mark_back_to_run", 32'(bus.ev_ready), 32'd1);
      check("mark_idle", 32'(busy), 32'd0);
      tick();
      check("mark_nwords", 32'(wq.size()), 32'd3);
      if (wq.size() == 3) begin
         check("mark_order0", 32'(wq[0]), 32'h0248);
         check("mark_order1", 32'(wq[1]), 32'h0716);
         check("mark_order2", 32'(wq[2]), 32'h1000);
      end
      check("mark_count", 32'(event_count), 32'd16);
      wq.delete(); wc.delete();

      // Marker with no preceding events
      bus.ts_valid = 1'b1;
      wait_ts_ready();
      check("mark2_word", 32'(bus.fifo_write_data), 32'h1000);
      bus.ts_valid = 1'b0;
      tick(); tick(); tick();
      check("mark2_single", 32'(wq.size()), 32'd1);
      check("mark2_count", 32'(event_count), 32'd16);
      wq.delete(); wc.delete();

      // enable=0 freezes a buffered event
      bus.ev_valid = 1'b1; bus.ev_x = 4'd9; bus.ev_y = 4'd10; bus.ev_spikes = 4'h5;
      tick();
      bus.ev_valid = 1'b0;
      enable = 1'b0;
      tick();
      check("frz_wr_en", 32'(bus.fifo_write_en), 32'd0);
      check("frz_ev_ready", 32'(bus.ev_ready), 32'd0);
      tick();
      check("frz_busy", 32'(busy), 32'd1);
      check("frz_count", 32'(event_count), 32'd16);
      check("frz_no_writes", 32'(wq.size()), 32'd0);
      enable = 1'b1;
      tick();
      check("thaw_wr_en", 32'(bus.fifo_write_en), 32'd1);
      check("thaw_word", 32'(bus.fifo_write_data), 32'h09A5);
      check("thaw_count", 32'(event_count), 32'd17);
      tick(); tick();
      wq.delete(); wc.delete();

      // Reset mid-operation discards buffered events and the pending marker
      bus.fifo_full_next = 1'b1;
      send(4'd4, 4'd4, 4'h4);
      send(4'd5, 4'd5, 4'h5);
      bus.ts_valid = 1'b1;
      tick();
      rst_n = 1'b0;
      bus.ts_valid = 1'b0;
      bus.fifo_full_next = 1'b0;
      tick();
      check("mrst_ev_ready", 32'(bus.ev_ready), 32'd0);
      check("mrst_wr_en", 32'(bus.fifo_write_en), 32'd0);
      check("mrst_wr_data", 32'(bus.fifo_write_data), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_count", 32'(event_count), 32'd0);
      rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      check("mrst_no_residual", 32'(wq.size()), 32'd0);
      check("mrst_ts_ready", 32'(bus.ts_ready), 32'd0);
      check("mrst_run", 32'(bus.ev_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
